// File: rtl/add_arb_pkg.sv
// Shared constants and output-state encoding for the two-requester adder arbiter.
package add_arb_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NUM_REQ   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/add_core.sv
// Combinational WIDTH-bit adder with carry-in and carry-out.
module add_core #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_arb_2ch.sv
// Two requesters share one adder through a round-robin grant; a single result
// register holds each sum until the consumer takes it.
module add_arb_2ch
  import add_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req0_chain,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic             req1_chain,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             carry_reg [NUM_REQ];
  logic             can_accept, grant, accept;
  logic [WIDTH-1:0] op_a, op_b, sum_w;
  logic             op_cin, cout_w;

  // Ties go to whichever requester was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_reg;
    else if (req1_valid)          grant = 1'b1;
  end

  assign can_accept = !rst && ((state_reg == IDLE) || rsp_ready);
  assign req0_ready = can_accept && (grant == 1'b0) && req0_valid;
  assign req1_ready = can_accept && (grant == 1'b1) && req1_valid;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_cin = req0_chain ? carry_reg[0] : req0_cin;
    if (grant) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_cin = req1_chain ? carry_reg[1] : req1_cin;
    end
  end

  add_core #(.WIDTH(WIDTH)) u_core (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_comb begin
    state_next = state_reg;
    if (accept)         state_next = HOLD;
    else if (rsp_ready) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign rsp_valid = (state_reg == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_sum        <= '0;
      rsp_cout       <= 1'b0;
      rsp_id         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      rsp_sum        <= sum_w;
      rsp_cout       <= cout_w;
      rsp_id         <= grant;
      last_grant_reg <= grant;
    end
  end

  // Each requester's saved carry only moves when that requester is accepted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_carry
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   carry_reg[gi] <= 1'b0;
      else if (accept && (grant == gi[0]))       carry_reg[gi] <= cout_w;
    end
  end

endmodule

// File: tb/tb_add_arb_2ch.sv
// Scoreboard bench for add_arb_2ch: a driver predicts grants and results from a
// behavioural model, a negedge monitor checks every presented response.
module tb_add_arb_2ch;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin, req0_chain;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin, req1_chain;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  add_arb_2ch #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_chain(req0_chain),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_chain(req1_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference model state
  logic m_carry [2];
  logic m_last;
  logic m_hold;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_carry[0] = 1'b0;
    m_carry[1] = 1'b0;
    m_last     = 1'b1;
    m_hold     = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive after the edge, then predict and check handshakes.
  task automatic do_cycle(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic c0, input logic ch0,
                          input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic c1, input logic ch1, input logic rr);
    logic         can, g, acc, cin;
    logic [W-1:0] a, b;
    logic [W:0]   full;
    rsp_t         r;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0; req0_chain = ch0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1; req1_chain = ch1;
    rsp_ready  = rr;
    #3;
    chk("rsp_valid", {{W{1'b0}}, rsp_valid}, {{W{1'b0}}, m_hold});
    can = !m_hold || rr;
    g   = (v0 && v1) ? !m_last : v1;
    acc = can && (v0 || v1);
    chk("req0_ready", {{W{1'b0}}, req0_ready}, {{W{1'b0}}, acc && !g});
    chk("req1_ready", {{W{1'b0}}, req1_ready}, {{W{1'b0}}, acc && g});
    if (acc) begin
      a    = g ? a1 : a0;
      b    = g ? b1 : b0;
      cin  = g ? (ch1 ? m_carry[1] : c1) : (ch0 ? m_carry[0] : c0);
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      r.id = g; r.sum = full[W-1:0]; r.cout = full[W];
      exp_q.push_back(r);
      m_carry[g] = full[W];
      m_last     = g;
    end
    m_hold = acc || (m_hold && !rr);
  endtask

  task automatic idle(input logic rr);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, rr);
  endtask

  task automatic op0(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input logic ch, input logic rr);
    do_cycle(1'b1, a, b, c, ch, 1'b0, '0, '0, 1'b0, 1'b0, rr);
  endtask

  task automatic op1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input logic ch, input logic rr);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a, b, c, ch, rr);
  endtask

  task automatic expect_rsp(input string name, input logic id, input logic [W-1:0] sum,
                            input logic cout);
    chk({name, "_valid"}, {{W{1'b0}}, rsp_valid}, {{W{1'b0}}, 1'b1});
    chk({name, "_id"},    {{W{1'b0}}, rsp_id},    {{W{1'b0}}, id});
    chk({name, "_sum"},   {1'b0, rsp_sum},        {1'b0, sum});
    chk({name, "_cout"},  {{W{1'b0}}, rsp_cout},  {{W{1'b0}}, cout});
  endtask

  // Asynchronous reset pulse placed between clock edges, with inputs valid.
  task automatic async_reset();
    #2;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {{W{1'b0}}, rsp_valid},  '0);
    chk("rst_req0_rdy",  {{W{1'b0}}, req0_ready}, '0);
    chk("rst_req1_rdy",  {{W{1'b0}}, req1_ready}, '0);
    chk("rst_sum",       {1'b0, rsp_sum},         '0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {{W{1'b0}}, 1'b1}, '0);
      end else begin
        chk("mon_id",   {{W{1'b0}}, rsp_id},   {{W{1'b0}}, exp_q[0].id});
        chk("mon_sum",  {1'b0, rsp_sum},       {1'b0, exp_q[0].sum});
        chk("mon_cout", {{W{1'b0}}, rsp_cout}, {{W{1'b0}}, exp_q[0].cout});
        if (rsp_ready) begin
          n_txn++;
          $display("txn %0d id=%0d sum=%h cout=%0d", n_txn, rsp_id, rsp_sum, rsp_cout);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_chain = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_chain = 1'b0;
    rsp_ready = 1'b1;
    model_reset();
    #2;
    chk("reset_valid", {{W{1'b0}}, rsp_valid},  '0);
    chk("reset_sum",   {1'b0, rsp_sum},         '0);
    chk("reset_cout",  {{W{1'b0}}, rsp_cout},   '0);
    chk("reset_id",    {{W{1'b0}}, rsp_id},     '0);
    chk("reset_rdy0",  {{W{1'b0}}, req0_ready}, '0);
    chk("reset_rdy1",  {{W{1'b0}}, req1_ready}, '0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single add, one-cycle latency, result held while consumer stalls
    op0(64'd5, 64'd7, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    expect_rsp("basic", 1'b0, 64'd13, 1'b0);
    idle(1'b1);

    // Both valid with free-running consumer: alternating grants
    for (int i = 0; i < 8; i++)
      do_cycle(1'b1, rnd64(), rnd64(), 1'b0, 1'b0, 1'b1, rnd64(), rnd64(), 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Overflow into saved carry, then chained use of it
    op1(ones, 64'd1, 1'b0, 1'b0, 1'b1);
    op1(64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    expect_rsp("wrap", 1'b1, 64'd0, 1'b1);
    idle(1'b0);
    expect_rsp("chain1", 1'b1, 64'd1, 1'b0);
    idle(1'b1);

    // 128-bit add on req0 with a req1 carry-clearing op in between
    op0(ones, 64'd1, 1'b0, 1'b0, 1'b1);
    op1(64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    op0(64'd2, 64'd3, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    expect_rsp("chain128_hi", 1'b0, 64'd6, 1'b0);
    idle(1'b1);

    // Consumer stall with both requesters waiting, then resume
    do_cycle(1'b1, 64'd10, 64'd1, 1'b0, 1'b0, 1'b1, 64'd20, 64'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 64'd10, 64'd1, 1'b0, 1'b0, 1'b1, 64'd20, 64'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 64'd10, 64'd1, 1'b0, 1'b0, 1'b1, 64'd20, 64'd2, 1'b0, 1'b0, 1'b1);

    // Reset mid-hold, then saved carries cleared and first tie to req0
    op0(ones, ones, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    async_reset();
    do_cycle(1'b1, 64'd5, 64'd7, 1'b1, 1'b1, 1'b1, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    expect_rsp("post_rst", 1'b0, 64'd12, 1'b0);
    idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      do_cycle($urandom_range(0, 3) != 0, rnd64(), rnd64(), 1'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0, rnd64(), rnd64(), 1'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0);

    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("drain_empty", W'(exp_q.size()) , '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
